// File: rtl/stream_pkg.sv
// Shared types and width helpers for the sample stream producer and its consumer.
package stream_pkg;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    localparam int unsigned MAX_FRAME_W = 1024;
    localparam int unsigned MAX_DATA_W  = 64;

    // Word index width; at least one bit so the counter always exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a sum of n zero-extended d-bit words.
    function automatic int unsigned sum_width(input int unsigned n, input int unsigned d);
        return $clog2(n) + d;
    endfunction

    // Word idx of a frame packed word 0 at the LSBs; the low dsize bits of the result are the word.
    function automatic logic [MAX_DATA_W-1:0] word_sel(input logic [MAX_FRAME_W-1:0] frame,
                                                       input int unsigned idx,
                                                       input int unsigned dsize);
        return MAX_DATA_W'(frame >> (idx * dsize));
    endfunction

endpackage

// File: rtl/en_reg.sv
// Enable-qualified register with synchronous active-low clear.
module en_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sample_streamer.sv
// Serialises parallel frames into a valid/ready word stream with one pending
// frame slot for bubble-free back-to-back frames and a per-frame checksum.
module sample_streamer
    import stream_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 2,
    parameter int unsigned DATA_SIZE   = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         load,
    input  logic [NUM_SAMPLES*DATA_SIZE-1:0]             loadData,
    output logic                                         loadReady,
    input  logic                                         outReady,
    output logic                                         validOutput,
    output logic [DATA_SIZE-1:0]                         dataOutput,
    output logic                                         lastOutput,
    output logic                                         done,
    output logic [sum_width(NUM_SAMPLES, DATA_SIZE)-1:0] frameSum
);

    localparam int unsigned IDX_W    = idx_width(NUM_SAMPLES);
    localparam int unsigned SUM_W    = sum_width(NUM_SAMPLES, DATA_SIZE);
    localparam int unsigned FRAME_W  = NUM_SAMPLES * DATA_SIZE;
    localparam int unsigned LAST_IDX = NUM_SAMPLES - 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_full_q, pend_full_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               done_q, done_d;

    logic [FRAME_W-1:0] active_q, active_d, pend_q;
    logic               active_en, pend_en, fsum_en;
    logic [SUM_W-1:0]   fsum_d;

    logic [DATA_SIZE-1:0] cur_word;
    logic                 streaming, is_last, xfer, final_xfer, load_acc;
    logic [SUM_W-1:0]     beat_sum;

    en_reg #(.W(FRAME_W)) u_active (
        .clk   (clk),
        .rst_n (rst),
        .en    (active_en),
        .d     (active_d),
        .q     (active_q)
    );

    en_reg #(.W(FRAME_W)) u_pend (
        .clk   (clk),
        .rst_n (rst),
        .en    (pend_en),
        .d     (loadData),
        .q     (pend_q)
    );

    en_reg #(.W(SUM_W)) u_fsum (
        .clk   (clk),
        .rst_n (rst),
        .en    (fsum_en),
        .d     (fsum_d),
        .q     (frameSum)
    );

    // Stream-side decode; everything here depends on registered state plus handshake inputs.
    always_comb begin
        cur_word    = DATA_SIZE'(word_sel(MAX_FRAME_W'(active_q), 32'(idx_q), DATA_SIZE));
        streaming   = (state_q == S_STREAM);
        is_last     = (idx_q == IDX_W'(LAST_IDX));
        loadReady   = !streaming || !pend_full_q;
        validOutput = streaming;
        dataOutput  = streaming ? cur_word : '0;
        lastOutput  = streaming && is_last;
        xfer        = streaming && outReady;
        final_xfer  = xfer && is_last;
        load_acc    = load && loadReady;
        beat_sum    = sum_q + SUM_W'(cur_word);
        fsum_d      = beat_sum;
        done        = done_q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_full_d = pend_full_q;
        sum_d       = sum_q;
        done_d      = 1'b0;
        active_en   = 1'b0;
        active_d    = loadData;
        pend_en     = 1'b0;
        fsum_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_acc) begin
                    active_en = 1'b1;
                    idx_d     = '0;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (load_acc && !final_xfer) begin
                    pend_en     = 1'b1;
                    pend_full_d = 1'b1;
                end
                if (xfer) begin
                    if (is_last) begin
                        done_d  = 1'b1;
                        fsum_en = 1'b1;
                        sum_d   = '0;
                        idx_d   = '0;
                        // Pending frame wins; otherwise a same-cycle load bypasses the slot.
                        if (pend_full_q) begin
                            active_en   = 1'b1;
                            active_d    = pend_q;
                            pend_full_d = 1'b0;
                        end else if (load_acc) begin
                            active_en = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        sum_d = beat_sum;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            sum_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_full_q <= pend_full_d;
            sum_q       <= sum_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: doc/sample_streamer.md
Name: sample_streamer

Overview:
- Producer end of the sample stream that tree_summer consumes. It drives tree_summer's validInput/dataInput and adds a ready back-pressure signal.
- Accepts a frame of NUM_SAMPLES words in parallel and emits the words one per beat, word 0 first, with valid/ready flow control and a last-word flag.
- Holds one pending frame so that consecutive frames stream with no bubble.
- Reports a per-frame checksum, sized like tree_summer's sum, so the two can be cross-checked.

Parameters:
- NUM_SAMPLES, 2, words per frame; must be >= 2.
- DATA_SIZE, 4, bits per word.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- load  input  1  a frame is offered on loadData.
- loadData  input  NUM_SAMPLES*DATA_SIZE  frame; word i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- loadReady  output  1  a frame offered this cycle will be accepted.
- outReady  input  1  downstream can take a beat.
- validOutput  output  1  dataOutput holds a valid beat.
- dataOutput  output  DATA_SIZE  current word.
- lastOutput  output  1  current beat is word NUM_SAMPLES-1.
- done  output  1  one-cycle pulse after the final beat of a frame.
- frameSum  output  $clog2(NUM_SAMPLES)+DATA_SIZE  sum of the words of the last completed frame.

Behaviour:
- Reset (rst==0 at a clock edge):
  - validOutput=0, dataOutput=0, lastOutput=0, done=0, frameSum=0, loadReady=1.
  - Word index idx=0; pending slot empty; running sum cleared; state S_IDLE.
  - Reset overrides every other input in the same cycle and discards any in-flight or pending frame.
- Load acceptance:
  - A load is accepted when load && loadReady.
  - loadReady = 1 in S_IDLE; in S_STREAM, loadReady = !pendFull.
  - loadReady is combinational from registered state only. It never depends on load or outReady.
- S_IDLE:
  - An accepted frame is copied into the active buffer, idx=0, next state S_STREAM.
  - validOutput rises the following cycle, giving 1-cycle latency from load to first beat.
- S_STREAM:
  - validOutput=1; dataOutput = active word[idx]; lastOutput = (idx==NUM_SAMPLES-1).
  - A beat transfers when validOutput && outReady. On transfer, idx increments and runningSum += word.
  - With outReady=0, dataOutput, lastOutput and idx hold stable.
- Load during S_STREAM, not on the final beat: the frame goes into the pending slot and pendFull=1.
- Final-beat transfer (idx==NUM_SAMPLES-1), in priority order:
  - (a) pendFull: pending is promoted to active, idx wraps to 0, pendFull=0, stay in S_STREAM.
  - (b) pending empty and a load is accepted in the same cycle: the loaded frame bypasses the pending slot into active, idx=0, stay in S_STREAM. There is no bubble.
  - (c) Otherwise: next state S_IDLE, validOutput=0 next cycle.
- Case (a) and a new load cannot coincide, because loadReady=0 while pendFull.
- Frame completion, on every final-beat transfer:
  - The cycle after, done=1 for exactly one cycle.
  - frameSum = runningSum + final word, held until the next completion.
  - runningSum is cleared for the next frame.
- Widths:
  - idx is $clog2(NUM_SAMPLES) bits and is forced to 0 at the frame end, including when NUM_SAMPLES is not a power of two.
  - The sum uses $clog2(NUM_SAMPLES)+DATA_SIZE bits, words zero-extended. It cannot overflow for power-of-two NUM_SAMPLES.
- States: S_IDLE, S_STREAM. The pending slot is a separate valid bit, not a state.

Decomposition:
- Package stream_pkg:
  - state enum {S_IDLE, S_STREAM};
  - function word_sel(frame, idx) returning DATA_SIZE bits;
  - constant helpers for index and sum widths.
  - The existing summer reuses the sum-width helper.
- No new sub-module. The active/pending frame registers and the frameSum register are instances of the existing enable register module.

Test Plan (NUM_SAMPLES=4, DATA_SIZE=4, frameSum 6 bits):
- Reset: hold rst=0 for 2 cycles with load=1 -> validOutput=0, loadReady=1, done=0, frameSum=0; no frame accepted.
- Single frame: load loadData=16'h4321 in S_IDLE with outReady=1 -> next cycle dataOutput 1,2,3,4 on consecutive cycles; lastOutput only with 4; done pulses the cycle after; frameSum=10; returns to S_IDLE.
- Stall: same frame, outReady=0 for 3 cycles while dataOutput=2 -> 2 held, idx unchanged, no extra beats; stream resumes 3,4; frameSum=10.
- Back-to-back: load 16'h4321, then 16'h8765 two cycles later -> loadReady=0 until promotion; output 1..8 with no gap; done twice, frameSum=10 then 26.
- Bypass on final beat: load 16'hFFFF in the same cycle as the final-beat transfer, pending empty -> next cycle dataOutput=F with no bubble; second done gives frameSum=60.
- Mid-frame reset: rst=0 at idx=2 with pending full -> all outputs cleared; a later load of 16'h1111 streams from word 0 with frameSum=4.
